alu_ctrl: RTL and testbench

Instruction sequencer that drives the registered 4-bit ALU from the controller side. It fetches 12-bit instructions from a synchronous program ROM, reads operands from a 4×4-bit register file, and issues `{op_code, cin}`, `en`, `A` and `B` to the ALU. It captures the ALU result one cycle later and writes it back. Together the two blocks form the datapath/control pair of the 4-bit CPU.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/alu_ctrl_regfile.sv | 30 +++
 rtl/alu_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types, func codes and field positions for the ALU sequencer
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // func is the ALU {op_code, cin} pair; the top two codes are controller-only.
  localparam logic [4:0] FN_MOV  = 5'b00000;
  localparam logic [4:0] FN_INC  = 5'b00001;
  localparam logic [4:0] FN_ADD  = 5'b00010;
  localparam logic [4:0] FN_ADDC = 5'b00011;
  localparam logic [4:0] FN_SUB  = 5'b00100;
  localparam logic [4:0] FN_DEC  = 5'b00110;
  localparam logic [4:0] FN_AND  = 5'b01000;
  localparam logic [4:0] FN_OR   = 5'b01010;
  localparam logic [4:0] FN_XOR  = 5'b01100;
  localparam logic [4:0] FN_NOT  = 5'b01110;
  localparam logic [4:0] FN_ZERO = 5'b10000;
  localparam logic [4:0] FN_LDI  = 5'b11110;
  localparam logic [4:0] FN_HALT = 5'b11111;

  localparam int FUNC_HI = 11;
  localparam int FUNC_LO = 7;
  localparam int RD_HI   = 6;
  localparam int RD_LO   = 5;
  localparam int RA_HI   = 4;
  localparam int RA_LO   = 3;
  localparam int RB_HI   = 2;
  localparam int RB_LO   = 1;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;

  function automatic logic is_legal_alu(input logic [4:0] func);
    return (func <= 5'b00111) ||
           (func inside {FN_AND, FN_OR, FN_XOR, FN_NOT, FN_ZERO});
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// rtl/alu_ctrl_regfile.sv - 4x4-bit register file, one write port, three combinational reads
module alu_ctrl_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [3:0] wd,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [1:0] dbg_sel,
  output logic [3:0] ra_data,
  output logic [3:0] rb_data,
  output logic [3:0] dbg_data
);

  logic [3:0] regs [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data  = regs[ra];
  assign rb_data  = regs[rb];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - instruction sequencer: fetch/decode/issue to the registered ALU, write back
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [11:0]     instr_data,
  output logic            alu_en,
  output logic [3:0]      alu_op,
  output logic            alu_cin,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_y,
  output logic            busy,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [3:0]      dbg_data
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [4:0]      func_q;
  logic [1:0]      rd_q;
  logic [3:0]      imm_q;
  logic [4:0]      dec_func;
  logic [3:0]      ra_data, rb_data;
  logic            rf_we;
  logic [3:0]      rf_wd;

  assign dec_func   = instr_data[FUNC_HI:FUNC_LO];
  assign instr_addr = pc;

  // Operand ports read straight off the ROM word so operands latch in DECODE.
  alu_ctrl_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .wa       (rd_q),
    .wd       (rf_wd),
    .ra       (instr_data[RA_HI:RA_LO]),
    .rb       (instr_data[RB_HI:RB_LO]),
    .dbg_sel  (dbg_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_next = ST_FETCH;
      ST_FETCH:         state_next = ST_DECODE;
      ST_DECODE: begin
        if (dec_func == FN_HALT)       state_next = ST_HALT;
        else if (is_legal_alu(dec_func)) state_next = ST_EXEC;
        else                           state_next = ST_WB;
      end
      ST_EXEC:          state_next = ST_WB;
      ST_WB:            state_next = ST_FETCH;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b1;
    halted = 1'b0;
    rf_we  = 1'b0;
    rf_wd  = alu_y;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      ST_WB: begin
        if (func_q == FN_LDI) begin
          rf_we = 1'b1;
          rf_wd = imm_q;
        end else if (is_legal_alu(func_q)) begin
          rf_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ALU-facing outputs are flops that only change in DECODE, so they hold through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      func_q  <= 5'd0;
      rd_q    <= 2'd0;
      imm_q   <= 4'd0;
      alu_en  <= 1'b0;
      alu_op  <= 4'd0;
      alu_cin <= 1'b0;
      alu_a   <= 4'd0;
      alu_b   <= 4'd0;
    end else begin
      alu_en <= (state_next == ST_EXEC);
      if ((state == ST_IDLE || state == ST_HALT) && start) pc <= '0;
      if (state == ST_WB) pc <= pc + PC_W'(1);
      if (state == ST_DECODE) begin
        func_q <= dec_func;
        rd_q   <= instr_data[RD_HI:RD_LO];
        imm_q  <= instr_data[IMM_HI:IMM_LO];
        if (is_legal_alu(dec_func)) begin
          alu_op  <= dec_func[4:1];
          alu_cin <= dec_func[0];
          alu_a   <= ra_data;
          alu_b   <= rb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed and randomized programs against an instruction-level reference model
module tb_alu_ctrl;

  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PC_W-1:0] instr_addr;
  logic [11:0]     instr_data;
  logic            alu_en;
  logic [3:0]      alu_op;
  logic            alu_cin;
  logic [3:0]      alu_a, alu_b, alu_y;
  logic            busy, halted;
  logic [1:0]      dbg_sel;
  logic [3:0]      dbg_data;

  int checks = 0;
  int failures = 0;

  logic [11:0] rom [16];
  logic [3:0]  ref_regs [4];
  logic [12:0] got_q [$];
  logic [12:0] exp_q [$];

  alu_ctrl #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .busy       (busy),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [4:0] f, input logic [3:0] a, input logic [3:0] b);
    int r;
    int ia = a;
    int ib = b;
    int c = f[0];
    case (f[4:1])
      4'd0:    r = ia + c;
      4'd1:    r = ia + ib + c;
      4'd2:    r = ia - ib - c;
      4'd3:    r = ia - 1 + c;
      4'd4:    r = ia & ib;
      4'd5:    r = ia | ib;
      4'd6:    r = ia ^ ib;
      4'd7:    r = ~ia;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  function automatic bit legal(input logic [4:0] f);
    return (f < 5'd8) || (f <= 5'd16 && f[0] == 1'b0);
  endfunction

  function automatic logic [11:0] op3(input logic [4:0] f, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
    return {f, rd, ra, rb, 1'b0};
  endfunction

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {5'b11110, rd, 1'b0, imm};
  endfunction

  localparam logic [11:0] HLT = 12'hF80;

  // Synchronous ROM and a registered ALU, as the controller sees them.
  always @(posedge clk) instr_data <= rom[instr_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) alu_y <= 4'd0;
    else if (alu_en) alu_y <= alu_fn({alu_op, alu_cin}, alu_a, alu_b);
  end

  always @(negedge clk) if (alu_en === 1'b1) got_q.push_back({alu_op, alu_cin, alu_a, alu_b});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural model: executes the ROM instruction by instruction.
  task automatic ref_run(output int cycles);
    int pc = 0;
    logic [11:0] w;
    logic [4:0] f;
    cycles = 0;
    exp_q.delete();
    for (int n = 0; n < 64; n++) begin
      w = rom[pc];
      f = w[11:7];
      if (f == 5'b11111) begin
        cycles += 2;
        return;
      end else if (f == 5'b11110) begin
        ref_regs[w[6:5]] = w[3:0];
        cycles += 3;
      end else if (legal(f)) begin
        exp_q.push_back({f, ref_regs[w[4:3]], ref_regs[w[2:1]]});
        ref_regs[w[6:5]] = alu_fn(f, ref_regs[w[4:3]], ref_regs[w[2:1]]);
        cycles += 4;
      end else begin
        cycles += 3;
      end
      pc = (pc + 1) % 16;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, ref_regs[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_prog(input string tag, output int got_cycles);
    int exp_cycles;
    int n;
    ref_run(exp_cycles);
    got_q.delete();
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    got_cycles = 0;
    while (!halted && got_cycles < 400) begin
      @(posedge clk);
      #1;
      got_cycles++;
    end
    check({tag, "_cycles"}, got_cycles, exp_cycles);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_en_pulses"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_issue%0d", tag, i), got_q[i], exp_q[i]);
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;
  endtask

  task automatic load(input logic [11:0] p [$]);
    for (int i = 0; i < 16; i++) rom[i] = (i < p.size()) ? p[i] : HLT;
  endtask

  initial begin
    int cyc;
    int k;
    int hp;
    int f;
    logic [11:0] prog [$];

    rst = 1'b1;
    start = 1'b0;
    dbg_sel = 2'd0;
    for (int i = 0; i < 16; i++) rom[i] = HLT;
    do_reset();

    check("rst_en", alu_en, 0);
    check("rst_op", {alu_op, alu_cin}, 0);
    check("rst_ab", {alu_a, alu_b}, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", instr_addr, 0);
    check_regs("rst");

    prog = '{ldi(0, 5), ldi(1, 3), op3(5'b00010, 2, 0, 1), op3(5'b00100, 3, 0, 1), HLT};
    load(prog);
    run_prog("basic", cyc);
    check("basic_16cyc", cyc, 16);
    dbg_sel = 2'd2; #1; check("basic_r2", dbg_data, 8);
    dbg_sel = 2'd3; #1; check("basic_r3", dbg_data, 2);

    prog = '{ldi(0, 0), op3(5'b00110, 1, 0, 0), ldi(2, 7), ldi(0, 4'hF), op3(5'b00001, 2, 0, 0), HLT};
    load(prog);
    run_prog("wrap", cyc);
    dbg_sel = 2'd1; #1; check("dec_r1", dbg_data, 4'hF);
    dbg_sel = 2'd2; #1; check("inc_r2", dbg_data, 4'h0);

    prog = '{ldi(0, 4'hC), ldi(1, 4'hA), op3(5'b01000, 2, 0, 1), op3(5'b01010, 3, 0, 1), HLT};
    load(prog);
    run_prog("logic_a", cyc);
    dbg_sel = 2'd2; #1; check("and_r2", dbg_data, 4'h8);
    dbg_sel = 2'd3; #1; check("or_r3", dbg_data, 4'hE);
    prog = '{op3(5'b01100, 2, 0, 1), op3(5'b01110, 3, 0, 0), HLT};
    load(prog);
    run_prog("logic_b", cyc);
    dbg_sel = 2'd2; #1; check("xor_r2", dbg_data, 4'h6);
    dbg_sel = 2'd3; #1; check("not_r3", dbg_data, 4'h3);
    prog = '{op3(5'b10000, 2, 0, 1), HLT};
    load(prog);
    run_prog("zero", cyc);
    dbg_sel = 2'd2; #1; check("zero_r2", dbg_data, 4'h0);

    prog = '{ldi(0, 5), op3(5'b01001, 0, 1, 1), ldi(1, 7), HLT};
    load(prog);
    run_prog("illegal", cyc);
    check("illegal_cycles", cyc, 11);
    check("illegal_no_en", got_q.size(), 0);
    dbg_sel = 2'd0; #1; check("illegal_r0", dbg_data, 5);

    for (int i = 0; i < 16; i++) rom[i] = ldi(2'(i % 4), 4'((i + 3) % 16));
    dbg_sel = 2'd0;
    pulse_start();
    for (int e = 1; e <= 51; e++) begin
      @(posedge clk);
      #1;
      if (e == 3)  check("pcwrap_1", instr_addr, 1);
      if (e == 45) check("pcwrap_15", instr_addr, 15);
      if (e == 48) begin
        check("pcwrap_0", instr_addr, 0);
        check("pcwrap_r0_old", dbg_data, 15);
      end
      if (e == 51) begin
        check("pcwrap_again", instr_addr, 1);
        check("pcwrap_r0_new", dbg_data, 3);
        check("pcwrap_busy", busy, 1);
      end
    end
    do_reset();

    prog = '{ldi(0, 5), ldi(1, 3), op3(5'b00010, 2, 0, 1), HLT};
    load(prog);
    pulse_start();
    k = 0;
    while (alu_en !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_reach_exec", alu_en, 1);
    rst = 1'b1;
    #1;
    check("mid_en", alu_en, 0);
    check("mid_op", {alu_op, alu_cin}, 0);
    check("mid_ab", {alu_a, alu_b}, 0);
    check("mid_busy", busy, 0);
    check("mid_halted", halted, 0);
    check("mid_pc", instr_addr, 0);
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;
    check_regs("mid");
    @(negedge clk);
    rst = 1'b0;
    run_prog("rerun", cyc);
    dbg_sel = 2'd2; #1; check("rerun_r2", dbg_data, 8);

    for (int t = 0; t < 4; t++) begin
      hp = $urandom_range(4, 15);
      for (int i = 0; i < 16; i++) begin
        k = $urandom_range(0, 9);
        if (k <= 6) f = int'($urandom_range(0, 12));
        if (k <= 6) f = (f < 8) ? f : 8 + 2 * (f - 8);
        else if (k <= 8) f = 30;
        else begin
          f = $urandom_range(9, 29);
          while (f <= 16 && f % 2 == 0) f = $urandom_range(9, 29);
        end
        rom[i] = {5'(f), 7'($urandom)};
      end
      rom[hp] = HLT;
      run_prog($sformatf("rand%0d", t), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
